// File: rtl/rx_ctrl_pkg.sv
// Shared types and default constants for the Simple Encoding receive controller.
// Contents: receiver state encoding and default symbol, data, sync and policy constants.
package rx_ctrl_pkg;

    localparam int unsigned DEF_SYM_W     = 10;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam logic [9:0]  DEF_SYNC_WORD = 10'b0011111011;
    localparam int unsigned DEF_LOCK_CNT  = 3;
    localparam int unsigned DEF_ERR_LIMIT = 4;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/rx_sym_fifo.sv
// Two-entry byte FIFO between the symbol decoder and the byte consumer.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   push, push_data   write request and data; accepted when not full or when popping
//   pop               read request; ignored when empty
//   head              oldest entry (valid when !empty)
//   full, empty       occupancy flags
module rx_sym_fifo
    import rx_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              wr_en_c;
    logic              rd_en_c;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_en_c = push && (!full || pop);
    assign rd_en_c = pop && !empty;

    assign head  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en_c) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en_c) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({wr_en_c, rd_en_c})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rx_sync_controller.sv
// Receive-side sequencer: deserialises the line into symbols, hunts for and
// confirms alignment on SYNC_WORD, feeds aligned symbols to an external
// combinational decoder and forwards good bytes through a 2-entry buffer.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   rx_bit, rx_bit_vld    serial line bit (symbol MSB first) and its valid
//   dec_sym               held symbol presented to the decoder
//   dec_data, dec_err     decoder result for dec_sym
//   out_data, out_valid   decoded byte stream to the consumer
//   out_ready             consumer accept
//   locked                receiver is locked
//   err_pulse             one-cycle pulse per decode error while locked
//   overflow              sticky byte-dropped flag
//   clr_stat              synchronous clear of overflow
module rx_sync_controller
    import rx_ctrl_pkg::*;
#(
    parameter int unsigned       SYM_W     = DEF_SYM_W,
    parameter int unsigned       DATA_W    = DEF_DATA_W,
    parameter logic [SYM_W-1:0]  SYNC_WORD = SYM_W'(DEF_SYNC_WORD),
    parameter int unsigned       LOCK_CNT  = DEF_LOCK_CNT,
    parameter int unsigned       ERR_LIMIT = DEF_ERR_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_bit,
    input  logic              rx_bit_vld,
    output logic [SYM_W-1:0]  dec_sym,
    input  logic [DATA_W-1:0] dec_data,
    input  logic              dec_err,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              locked,
    output logic              err_pulse,
    output logic              overflow,
    input  logic              clr_stat
);

    localparam int unsigned BC_W = $clog2(SYM_W);
    localparam int unsigned SC_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned EC_W = $clog2(ERR_LIMIT + 1);

    state_t            state;
    logic [SYM_W-1:0]  win;
    logic [BC_W-1:0]   bit_cnt;
    logic [SC_W-1:0]   sync_cnt;
    logic [EC_W-1:0]   err_cnt;
    logic              eval;

    logic [SYM_W-1:0]  win_c;
    logic              is_sync_c;
    logic              boundary_c;
    logic              push_c;
    logic              pop_c;
    logic              drop_c;
    logic              fifo_full;
    logic              fifo_empty;

    // Window as it will look after this cycle's bit is shifted in.
    assign win_c      = {win[SYM_W-2:0], rx_bit};
    assign is_sync_c  = (win_c == SYNC_WORD);
    // Boundary only has meaning once an alignment has been chosen.
    assign boundary_c = rx_bit_vld && (state != ST_HUNT) && (bit_cnt == BC_W'(SYM_W - 1));

    // The decoder answer is sampled one cycle after the hold register loads.
    assign push_c = eval && !dec_err;
    assign pop_c  = out_valid && out_ready;
    assign drop_c = push_c && fifo_full && !pop_c;

    assign out_valid = !fifo_empty;

    // Shifter, counters, state machine, decoder hold register and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HUNT;
            win       <= '0;
            bit_cnt   <= '0;
            sync_cnt  <= '0;
            err_cnt   <= '0;
            eval      <= 1'b0;
            dec_sym   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            eval      <= 1'b0;

            if (rx_bit_vld) begin
                win     <= win_c;
                bit_cnt <= (bit_cnt == BC_W'(SYM_W - 1)) ? '0 : bit_cnt + BC_W'(1);
            end

            case (state)
                ST_HUNT: begin
                    if (rx_bit_vld && is_sync_c) begin
                        bit_cnt  <= '0;
                        sync_cnt <= SC_W'(1);
                        err_cnt  <= '0;
                        if (LOCK_CNT == 1) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state <= ST_CONFIRM;
                        end
                    end
                end

                ST_CONFIRM: begin
                    if (boundary_c) begin
                        if (is_sync_c) begin
                            sync_cnt <= sync_cnt + SC_W'(1);
                            if (sync_cnt == SC_W'(LOCK_CNT - 1)) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            state    <= ST_HUNT;
                            sync_cnt <= '0;
                        end
                    end
                end

                ST_LOCKED: begin
                    // Idle sync symbols are dropped without touching err_cnt.
                    if (boundary_c && !is_sync_c) begin
                        dec_sym <= win_c;
                        eval    <= 1'b1;
                    end
                    if (eval) begin
                        if (dec_err) begin
                            err_pulse <= 1'b1;
                            if (err_cnt == EC_W'(ERR_LIMIT - 1)) begin
                                state    <= ST_HUNT;
                                locked   <= 1'b0;
                                err_cnt  <= '0;
                                sync_cnt <= '0;
                            end else begin
                                err_cnt <= err_cnt + EC_W'(1);
                            end
                        end else begin
                            err_cnt <= '0;
                        end
                    end
                end

                default: begin
                    state  <= ST_HUNT;
                    locked <= 1'b0;
                end
            endcase

            // A drop in the same cycle as a clear keeps the flag set.
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clr_stat) begin
                overflow <= 1'b0;
            end
        end
    end

    rx_sym_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .push_data (dec_data),
        .pop       (pop_c),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_rx_sync_controller.sv
// Directed bench for rx_sync_controller with a small table-driven decoder model.
module tb_rx_sync_controller;

    localparam logic [9:0] SYNC  = 10'b0011111011;
    localparam logic [9:0] S_A5  = 10'b0111010011;
    localparam logic [9:0] S_3C  = 10'b1011000110;
    localparam logic [9:0] S_5A  = 10'b1100101001;
    localparam logic [9:0] S_BAD = 10'b1111111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_bit = 1'b0;
    logic       rx_bit_vld = 1'b0;
    logic [9:0] dec_sym;
    logic [7:0] dec_data;
    logic       dec_err;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       locked;
    logic       err_pulse;
    logic       overflow;
    logic       clr_stat = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    // Decoder model: three known data symbols, everything else is an error.
    assign dec_data = (dec_sym == S_A5) ? 8'hA5 :
                      (dec_sym == S_3C) ? 8'h3C :
                      (dec_sym == S_5A) ? 8'h5A : 8'h00;
    assign dec_err  = !((dec_sym == S_A5) || (dec_sym == S_3C) || (dec_sym == S_5A));

    always @(negedge clk) if (err_pulse === 1'b1) pulse_cnt++;

    rx_sync_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_bit     (rx_bit),
        .rx_bit_vld (rx_bit_vld),
        .dec_sym    (dec_sym),
        .dec_data   (dec_data),
        .dec_err    (dec_err),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .overflow   (overflow),
        .clr_stat   (clr_stat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_bit     = b;
        rx_bit_vld = 1'b1;
        tick();
        rx_bit_vld = 1'b0;
    endtask

    // Returns one cycle after the boundary edge (the eval cycle).
    task automatic send_sym(input logic [9:0] s);
        for (int i = 9; i >= 0; i--) begin
            rx_bit     = s[i];
            rx_bit_vld = 1'b1;
            tick();
        end
        rx_bit_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({out_valid, locked, err_pulse, overflow} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got valid/locked/err/ovf=%b expected 0000",
                     {out_valid, locked, err_pulse, overflow});
        end
        tests_run++;
        if ({dec_sym, out_data} !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got dec_sym=%b out_data=%h expected 0", dec_sym, out_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lock();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_sym(SYNC);
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_sync1: got locked=%b expected 0", locked);
        end
        send_sym(SYNC);
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_sync2: got locked=%b expected 0", locked);
        end
        send_sym(SYNC);
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL lock_sync3: got locked=%b expected 1", locked);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_no_out: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_data();
        send_sym(S_A5);
        tests_run++;
        if (dec_sym !== S_A5 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL data_t1: got dec_sym=%b out_valid=%b expected %b/0", dec_sym, out_valid, S_A5);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL data_t2: got out_valid=%b out_data=%h expected 1/a5", out_valid, out_data);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL data_popped: got out_valid=%b expected 0", out_valid);
        end
        send_sym(SYNC);
        tick();
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || dec_sym !== S_A5) begin
            tests_failed++;
            $display("FAIL data_idle: got out_valid=%b dec_sym=%b expected 0/%b", out_valid, dec_sym, S_A5);
        end
    endtask

    task automatic test_errors();
        int start;
        start = pulse_cnt;
        send_sym(S_BAD); send_sym(S_BAD); send_sym(S_BAD);
        send_sym(S_A5);
        send_sym(S_BAD); send_sym(S_BAD); send_sym(S_BAD);
        tick();
        tick();
        tests_run++;
        if (locked !== 1'b1 || pulse_cnt - start !== 6) begin
            tests_failed++;
            $display("FAIL err_3g3: got locked=%b pulses=%0d expected 1/6", locked, pulse_cnt - start);
        end
        send_sym(S_3C);
        start = pulse_cnt;
        send_sym(S_BAD); send_sym(S_BAD); send_sym(S_BAD); send_sym(S_BAD);
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL err4_before_eval: got locked=%b expected 1", locked);
        end
        tick();
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL err4_unlock: got locked=%b expected 0", locked);
        end
        tick();
        tests_run++;
        if (pulse_cnt - start !== 4) begin
            tests_failed++;
            $display("FAIL err4_pulses: got %0d expected 4", pulse_cnt - start);
        end
    endtask

    task automatic test_confirm_realign();
        send_sym(SYNC);
        send_sym(S_A5);
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL confirm_bad: got locked=%b expected 0", locked);
        end
        send_bit(1'b1);
        send_sym(SYNC);
        send_sym(SYNC);
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL realign_sync2: got locked=%b expected 0", locked);
        end
        send_sym(SYNC);
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL realign_sync3: got locked=%b expected 1", locked);
        end
        send_sym(S_3C);
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL realign_data: got out_valid=%b out_data=%h expected 1/3c", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        send_sym(S_A5); send_sym(S_3C); send_sym(S_5A);
        tick();
        tests_run++;
        if (overflow !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL ovf_drop: got ovf=%b valid=%b data=%h expected 1/1/a5", overflow, out_valid, out_data);
        end
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clear: got overflow=%b expected 0", overflow);
        end
        send_sym(S_A5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (overflow !== 1'b0 || out_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL ovf_push_pop: got ovf=%b head=%h expected 0/3c", overflow, out_data);
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL ovf_drain: got valid=%b data=%h expected 1/a5", out_valid, out_data);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_empty: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send_sym(S_A5); send_sym(S_3C); send_sym(S_5A);
        tick();
        tests_run++;
        if (overflow !== 1'b1 || out_valid !== 1'b1 || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_pre: got ovf=%b valid=%b locked=%b expected 111", overflow, out_valid, locked);
        end
        for (int i = 9; i >= 5; i--) begin
            rx_bit     = S_A5[i];
            rx_bit_vld = 1'b1;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, locked, err_pulse, overflow} !== 4'b0000 || out_data !== 8'h00 || dec_sym !== 10'd0) begin
            tests_failed++;
            $display("FAIL arst_async: got valid/locked/err/ovf=%b data=%h dec_sym=%b expected 0",
                     {out_valid, locked, err_pulse, overflow}, out_data, dec_sym);
        end
        rx_bit_vld = 1'b0;
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_after: got valid=%b locked=%b expected 0/0", out_valid, locked);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_lock();
        test_data();
        test_errors();
        test_confirm_realign();
        test_overflow();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
